// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO
// registers. One iteration per cycle; Busy covers the whole operation so the
// hazard logic can stall MFHI/MFLO and any new mul/div until Done.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  HiWrite,
  input  logic                  LoWrite,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           isDiv_q, isDiv_d;
  logic           negMain_q, negMain_d;
  logic           negRem_q, negRem_d;
  logic           divZero_q, divZero_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [N-1:0]   workHi_q, workHi_d;
  logic [N-1:0]   workLo_q, workLo_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic           aNeg, bNeg;
  logic [N-1:0]   magA, magB;
  logic [N-1:0]   addend;
  logic [N:0]     mulSum;
  logic [N:0]     remShift;
  logic           remFits;
  logic [2*N-1:0] mulProd;
  logic [N-1:0]   fixQuo, fixRem;

  // Operand magnitudes, one mul/div iteration, and the sign fix-up results.
  // The magnitude of an N+1-bit sign-extended operand always fits in N bits,
  // so the most negative value needs no special casing.
  always_comb begin
    aNeg     = ~Op[0] & A[N-1];
    bNeg     = ~Op[0] & B[N-1];
    magA     = aNeg ? -A : A;
    magB     = bNeg ? -B : B;
    addend   = workLo_q[0] ? opnd_q : '0;
    mulSum   = {1'b0, workHi_q} + {1'b0, addend};
    remShift = {workHi_q, workLo_q[N-1]};
    remFits  = (remShift >= {1'b0, opnd_q});
    mulProd  = {workHi_q, workLo_q};
    if (negMain_q) mulProd = -mulProd;
    fixQuo   = negMain_q ? -workLo_q : workLo_q;
    if (divZero_q) fixQuo = '1;
    fixRem   = negRem_q ? -workHi_q : workHi_q;
  end

  // Next-state logic: IDLE accepts Start and MTHI/MTLO, CALC iterates,
  // FIX applies signs and writes HI/LO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    negMain_d = negMain_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    opnd_d    = opnd_q;
    workHi_d  = workHi_q;
    workLo_d  = workLo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (HiWrite) hi_d = WrData;
        if (LoWrite) lo_d = WrData;
        if (Start) begin
          isDiv_d   = Op[1];
          negMain_d = aNeg ^ bNeg;
          negRem_d  = aNeg;
          divZero_d = (B == '0);
          opnd_d    = Op[1] ? magB : magA;
          workLo_d  = Op[1] ? magA : magB;
          workHi_d  = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (isDiv_q) begin
          workHi_d = remFits ? N'(remShift - {1'b0, opnd_q}) : remShift[N-1:0];
          workLo_d = {workLo_q[N-2:0], remFits};
        end else begin
          workHi_d = mulSum[N:1];
          workLo_d = {mulSum[0], workLo_q[N-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) state_d = FIX;
      end
      FIX: begin
        if (isDiv_q) begin
          hi_d = fixRem;
          lo_d = fixQuo;
        end else begin
          hi_d = mulProd[2*N-1:N];
          lo_d = mulProd[N-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation and clears HI/LO.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negMain_q <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      opnd_q    <= '0;
      workHi_q  <= '0;
      workLo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      negMain_q <= negMain_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      opnd_q    <= opnd_d;
      workHi_q  <= workHi_d;
      workLo_q  <= workLo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer
// against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int N = 32;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [1:0]    Op;
  logic [N-1:0]  A, B;
  logic          HiWrite, LoWrite;
  logic [N-1:0]  WrData;
  logic          Busy, Done;
  logic [N-1:0]  Hi, Lo;

  int testCount = 0;
  int failCount = 0;
  logic [N-1:0] expHi = '0;
  logic [N-1:0] expLo = '0;

  muldiv_sequencer #(.DATA_WIDTH(N)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: plain 64-bit arithmetic with truncating signed division.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFFFFFF;
          eh = a;
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = 64'(q); el = p[31:0];
          p = 64'(r); eh = p[31:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation from an IDLE cycle; optionally writes HI at Start and
  // optionally pokes Start/MTHI/MTLO while busy. Leaves us #1 after Done.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit writeAtStart, input bit interfere, input string tag);
    logic [31:0] eh, el;
    int edges;
    bit seen;
    model(op, a, b, eh, el);
    Start = 1'b1; Op = op; A = a; B = b;
    HiWrite = writeAtStart; LoWrite = 1'b0; WrData = 32'h5A5A5A5A;
    @(posedge Clk); #1;
    if (writeAtStart) begin
      expHi = 32'h5A5A5A5A;
      checkOutput({tag, " hi written at start"}, Hi, expHi);
    end
    Start = 1'b0; HiWrite = 1'b0;
    Op = 2'($urandom); A = $urandom; B = $urandom;
    checkOutput({tag, " busy after start"}, {31'b0, Busy}, 32'd1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < N + 10) begin
      if (interfere && edges == 3) begin
        Start = 1'b1; Op = 2'b01; A = 32'h7; B = 32'h9;
        HiWrite = 1'b1; LoWrite = 1'b1; WrData = 32'hDEADBEEF;
      end else begin
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      end
      @(posedge Clk); #1;
      edges++;
      if (Done) seen = 1'b1;
      else if (edges == 5) begin
        checkOutput({tag, " hi held while busy"}, Hi, expHi);
        checkOutput({tag, " lo held while busy"}, Lo, expLo);
      end
    end
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    checkOutput({tag, " done latency"}, 32'(edges), 32'(N + 1));
    checkOutput({tag, " hi"}, Hi, eh);
    checkOutput({tag, " lo"}, Lo, el);
    checkOutput({tag, " busy clear at done"}, {31'b0, Busy}, 32'd0);
    expHi = eh;
    expLo = el;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    int edges;
    bit doneSeen;

    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WrData = '0;
    @(posedge Clk); #1;
    Start = 1'b1; HiWrite = 1'b1; LoWrite = 1'b1; WrData = 32'hFFFF0000; A = 32'd3; B = 32'd5;
    @(posedge Clk); #1;
    checkOutput("reset busy", {31'b0, Busy}, 32'd0);
    checkOutput("reset done", {31'b0, Done}, 32'd0);
    checkOutput("reset hi", Hi, 32'd0);
    checkOutput("reset lo", Lo, 32'd0);
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; Reset = 1'b0;
    @(posedge Clk); #1;

    applyStimulus(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "multu max*2");
    @(posedge Clk); #1;
    checkOutput("done single pulse", {31'b0, Done}, 32'd0);
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, "mult -3*5");
    applyStimulus(2'b00, 32'h80000000, 32'h80000000, 1'b0, 1'b0, "mult min*min");
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div -7/2");
    applyStimulus(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, "divu 7/2");
    applyStimulus(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, "div 7/-2");
    applyStimulus(2'b11, 32'h1234, 32'd0, 1'b0, 1'b0, "divu by zero");
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0, "div neg by zero");
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div overflow");
    applyStimulus(2'b00, 32'h12345678, 32'hFEDCBA98, 1'b0, 1'b1, "mult with interference");
    applyStimulus(2'b11, 32'hCAFEF00D, 32'd77, 1'b1, 1'b0, "divu with start write");

    HiWrite = 1'b1; WrData = 32'hDEADBEEF;
    @(posedge Clk); #1;
    HiWrite = 1'b0;
    checkOutput("mthi idle", Hi, 32'hDEADBEEF);
    checkOutput("mthi leaves lo", Lo, expLo);
    LoWrite = 1'b1; WrData = 32'h0BADF00D;
    @(posedge Clk); #1;
    LoWrite = 1'b0;
    checkOutput("mtlo idle", Lo, 32'h0BADF00D);
    checkOutput("mtlo leaves hi", Hi, 32'hDEADBEEF);
    expHi = 32'hDEADBEEF;
    expLo = 32'h0BADF00D;

    Start = 1'b1; Op = 2'b10; A = 32'd1000; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge Clk); #1;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checkOutput("mid-op reset busy", {31'b0, Busy}, 32'd0);
    checkOutput("mid-op reset hi", Hi, 32'd0);
    checkOutput("mid-op reset lo", Lo, 32'd0);
    doneSeen = 1'b0;
    edges = 0;
    while (edges < N + 8) begin
      @(posedge Clk); #1;
      edges++;
      if (Done || Busy) doneSeen = 1'b1;
    end
    checkOutput("no done after reset", {31'b0, doneSeen}, 32'd0);
    expHi = '0;
    expLo = '0;
    applyStimulus(2'b10, 32'd1000, 32'd7, 1'b0, 1'b0, "div after reset");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(rop, ra, rb, 1'b0, 1'b0, $sformatf("random %0d op%0d", i, rop));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
